// File: rtl/qdrii_port_arbiter.sv
// Two-requester round-robin arbiter sharing QDRII user port 0.
// Read data is routed back to the issuing requester through an in-order tag FIFO.
module qdrii_port_arbiter #(
    parameter int ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH      = 72,
    parameter int BW_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst_clk,
    input  logic                               cal_done,
    input  logic                               clear_error,
    input  logic                               rqA_valid,
    output logic                               rqA_ready,
    input  logic                               rqA_we,
    input  logic [ADDR_WIDTH-1:0]              rqA_addr,
    input  logic [DATA_WIDTH-1:0]              rqA_wdata,
    input  logic [BW_WIDTH-1:0]                rqA_bw_n,
    input  logic                               rqB_valid,
    output logic                               rqB_ready,
    input  logic                               rqB_we,
    input  logic [ADDR_WIDTH-1:0]              rqB_addr,
    input  logic [DATA_WIDTH-1:0]              rqB_wdata,
    input  logic [BW_WIDTH-1:0]                rqB_bw_n,
    output logic                               rspA_valid,
    output logic [DATA_WIDTH-1:0]              rspA_data,
    output logic                               rspB_valid,
    output logic [DATA_WIDTH-1:0]              rspB_data,
    output logic                               user_wr_cmd0,
    output logic [ADDR_WIDTH-1:0]              user_wr_addr0,
    output logic [DATA_WIDTH-1:0]              user_wr_data0,
    output logic [BW_WIDTH-1:0]                user_wr_bw_n0,
    output logic                               user_rd_cmd0,
    output logic [ADDR_WIDTH-1:0]              user_rd_addr0,
    input  logic                               user_rd_valid0,
    input  logic [DATA_WIDTH-1:0]              user_rd_data0,
    output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding,
    output logic                               err_unexpected,
    output logic                               busy
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_CAL_WAIT, S_RUN, S_DRAIN} state_t;

    state_t                 state, state_nxt;
    logic                   prefer_b;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   fifo_full, fifo_empty;
    logic                   elig_a, elig_b;
    logic                   xfer, xfer_we, push, pop, head_id;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [BW_WIDTH-1:0]    sel_bw_n;

    assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);

    always_comb begin
        state_nxt = state;
        elig_a    = 1'b0;
        elig_b    = 1'b0;
        case (state)
            S_CAL_WAIT: if (cal_done) state_nxt = S_RUN;
            S_RUN: begin
                // A read needs a free tag slot; a same-cycle pop does not count.
                elig_a = rqA_valid && (rqA_we || !fifo_full);
                elig_b = rqB_valid && (rqB_we || !fifo_full);
                if (!cal_done) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (fifo_empty) state_nxt = S_CAL_WAIT;
            default: state_nxt = S_CAL_WAIT;
        endcase
    end

    assign rqA_ready = elig_a && (!elig_b || !prefer_b);
    assign rqB_ready = elig_b && (!elig_a || prefer_b);

    assign xfer      = rqA_ready || rqB_ready;
    assign xfer_we   = rqA_ready ? rqA_we    : rqB_we;
    assign sel_addr  = rqA_ready ? rqA_addr  : rqB_addr;
    assign sel_wdata = rqA_ready ? rqA_wdata : rqB_wdata;
    assign sel_bw_n  = rqA_ready ? rqA_bw_n  : rqB_bw_n;
    assign push      = xfer && !xfer_we;
    assign pop       = user_rd_valid0 && !fifo_empty;
    assign head_id   = tag_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            state <= S_CAL_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= rqB_ready;
    end

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            prefer_b       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            err_unexpected <= 1'b0;
            user_wr_cmd0   <= 1'b0;
            user_rd_cmd0   <= 1'b0;
            user_wr_addr0  <= '0;
            user_wr_data0  <= '0;
            user_wr_bw_n0  <= '0;
            user_rd_addr0  <= '0;
            rspA_valid     <= 1'b0;
            rspB_valid     <= 1'b0;
            rspA_data      <= '0;
            rspB_data      <= '0;
        end else begin
            user_wr_cmd0 <= xfer && xfer_we;
            user_rd_cmd0 <= push;
            if (xfer) prefer_b <= rqA_ready;
            if (xfer && xfer_we) begin
                user_wr_addr0 <= sel_addr;
                user_wr_data0 <= sel_wdata;
                user_wr_bw_n0 <= sel_bw_n;
            end
            if (push) begin
                user_rd_addr0 <= sel_addr;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);

            rspA_valid <= pop && !head_id;
            rspB_valid <= pop && head_id;
            if (pop && !head_id) rspA_data <= user_rd_data0;
            if (pop && head_id)  rspB_data <= user_rd_data0;

            // A stray return outranks a coincident clear.
            if (user_rd_valid0 && fifo_empty) err_unexpected <= 1'b1;
            else if (clear_error)             err_unexpected <= 1'b0;
        end
    end

    assign rd_outstanding = count;
    assign busy           = (state != S_CAL_WAIT) || !fifo_empty;

endmodule

// File: tb/tb_qdrii_port_arbiter.sv
// Randomized bench for qdrii_port_arbiter against a queue-based reference model
// of the arbitration, tag routing and calibration gating rules.
module tb_qdrii_port_arbiter;
    localparam int AW = 20, DW = 72, BWW = 8, MAXO = 8, CW = 4;

    logic clk = 1'b0;
    logic rst_clk, cal_done, clear_error;
    logic rqA_valid, rqA_ready, rqA_we, rqB_valid, rqB_ready, rqB_we;
    logic [AW-1:0] rqA_addr, rqB_addr, user_wr_addr0, user_rd_addr0;
    logic [DW-1:0] rqA_wdata, rqB_wdata, rspA_data, rspB_data, user_wr_data0, user_rd_data0;
    logic [BWW-1:0] rqA_bw_n, rqB_bw_n, user_wr_bw_n0;
    logic rspA_valid, rspB_valid, user_wr_cmd0, user_rd_cmd0, user_rd_valid0;
    logic [CW-1:0] rd_outstanding;
    logic err_unexpected, busy;

    qdrii_port_arbiter dut (
        .clk(clk), .rst_clk(rst_clk), .cal_done(cal_done), .clear_error(clear_error),
        .rqA_valid(rqA_valid), .rqA_ready(rqA_ready), .rqA_we(rqA_we), .rqA_addr(rqA_addr),
        .rqA_wdata(rqA_wdata), .rqA_bw_n(rqA_bw_n),
        .rqB_valid(rqB_valid), .rqB_ready(rqB_ready), .rqB_we(rqB_we), .rqB_addr(rqB_addr),
        .rqB_wdata(rqB_wdata), .rqB_bw_n(rqB_bw_n),
        .rspA_valid(rspA_valid), .rspA_data(rspA_data), .rspB_valid(rspB_valid), .rspB_data(rspB_data),
        .user_wr_cmd0(user_wr_cmd0), .user_wr_addr0(user_wr_addr0), .user_wr_data0(user_wr_data0),
        .user_wr_bw_n0(user_wr_bw_n0), .user_rd_cmd0(user_rd_cmd0), .user_rd_addr0(user_rd_addr0),
        .user_rd_valid0(user_rd_valid0), .user_rd_data0(user_rd_data0),
        .rd_outstanding(rd_outstanding), .err_unexpected(err_unexpected), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [DW-1:0] data; } ret_t;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, last_due = 0, lat_min = 5, lat_max = 5;
    bit auto_ret = 0;
    ret_t ret_q[$];
    logic [DW-1:0] mem [int];

    // Reference model: phase 0 = waiting for calibration, 1 = running, 2 = draining.
    int  phase;
    bit  m_tags[$];
    bit  m_pref_b, m_err;
    logic e_wr_cmd, e_rd_cmd, e_rspA_v, e_rspB_v;
    logic [AW-1:0] e_wr_addr, e_rd_addr;
    logic [DW-1:0] e_wr_data, e_rspA_d, e_rspB_d;
    logic [BWW-1:0] e_wr_bw;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    task automatic model_reset();
        phase = 0; m_tags.delete(); m_pref_b = 0; m_err = 0;
        e_wr_cmd = 0; e_rd_cmd = 0; e_rspA_v = 0; e_rspB_v = 0;
        e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0; e_wr_bw = '0;
        e_rspA_d = '0; e_rspB_d = '0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_rdyA"}, DW'(rqA_ready), '0);
        check_eq({pfx, "_rdyB"}, DW'(rqB_ready), '0);
        check_eq({pfx, "_wr_cmd"}, DW'(user_wr_cmd0), '0);
        check_eq({pfx, "_rd_cmd"}, DW'(user_rd_cmd0), '0);
        check_eq({pfx, "_wr_addr"}, DW'(user_wr_addr0), '0);
        check_eq({pfx, "_wr_data"}, user_wr_data0, '0);
        check_eq({pfx, "_wr_bw"}, DW'(user_wr_bw_n0), '0);
        check_eq({pfx, "_rd_addr"}, DW'(user_rd_addr0), '0);
        check_eq({pfx, "_rspA_v"}, DW'(rspA_valid), '0);
        check_eq({pfx, "_rspB_v"}, DW'(rspB_valid), '0);
        check_eq({pfx, "_rspA_d"}, rspA_data, '0);
        check_eq({pfx, "_rspB_d"}, rspB_data, '0);
        check_eq({pfx, "_cnt"}, DW'(rd_outstanding), '0);
        check_eq({pfx, "_err"}, DW'(err_unexpected), '0);
        check_eq({pfx, "_busy"}, DW'(busy), '0);
    endtask

    // One clock: inputs are set at posedge+1, checked at negedge, model advanced.
    task automatic cycle();
        bit ea, eb, ga, gb, we, id;
        int sz0, due;
        logic [AW-1:0] ad;
        ret_t r;
        if (auto_ret) begin
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                user_rd_valid0 = 1'b1; user_rd_data0 = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                user_rd_valid0 = 1'b0; user_rd_data0 = rnd();
            end
        end
        @(negedge clk);
        check_eq("wr_cmd", DW'(user_wr_cmd0), DW'(e_wr_cmd));
        check_eq("rd_cmd", DW'(user_rd_cmd0), DW'(e_rd_cmd));
        check_eq("wr_addr", DW'(user_wr_addr0), DW'(e_wr_addr));
        check_eq("wr_data", user_wr_data0, e_wr_data);
        check_eq("wr_bw", DW'(user_wr_bw_n0), DW'(e_wr_bw));
        check_eq("rd_addr", DW'(user_rd_addr0), DW'(e_rd_addr));
        check_eq("rspA_v", DW'(rspA_valid), DW'(e_rspA_v));
        check_eq("rspB_v", DW'(rspB_valid), DW'(e_rspB_v));
        check_eq("rspA_d", rspA_data, e_rspA_d);
        check_eq("rspB_d", rspB_data, e_rspB_d);
        check_eq("outstanding", DW'(rd_outstanding), DW'(m_tags.size()));
        check_eq("err", DW'(err_unexpected), DW'(m_err));
        check_eq("busy", DW'(busy), DW'(phase != 0 || m_tags.size() != 0));

        sz0 = m_tags.size();
        ea = (phase == 1) && rqA_valid && (rqA_we || sz0 < MAXO);
        eb = (phase == 1) && rqB_valid && (rqB_we || sz0 < MAXO);
        ga = ea && (!eb || !m_pref_b);
        gb = eb && !ga;
        check_eq("rdyA", DW'(rqA_ready), DW'(ga));
        check_eq("rdyB", DW'(rqB_ready), DW'(gb));

        e_wr_cmd = 0; e_rd_cmd = 0; e_rspA_v = 0; e_rspB_v = 0;
        if (user_rd_valid0) begin
            if (sz0 == 0) m_err = 1;
            else begin
                id = m_tags.pop_front();
                if (id) begin e_rspB_v = 1; e_rspB_d = user_rd_data0; end
                else    begin e_rspA_v = 1; e_rspA_d = user_rd_data0; end
            end
        end
        if (clear_error && !(user_rd_valid0 && sz0 == 0)) m_err = 0;

        if (ga || gb) begin
            we = ga ? rqA_we : rqB_we;
            ad = ga ? rqA_addr : rqB_addr;
            m_pref_b = ga;
            if (we) begin
                e_wr_cmd = 1; e_wr_addr = ad;
                e_wr_data = ga ? rqA_wdata : rqB_wdata;
                e_wr_bw = ga ? rqA_bw_n : rqB_bw_n;
                mem[int'(ad)] = e_wr_data;
            end else begin
                e_rd_cmd = 1; e_rd_addr = ad;
                m_tags.push_back(gb);
                if (auto_ret) begin
                    due = cyc + 1 + int'($urandom_range(lat_min, lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    r.due = due;
                    r.data = mem.exists(int'(ad)) ? mem[int'(ad)] : rnd();
                    ret_q.push_back(r);
                end
            end
        end

        case (phase)
            0: if (cal_done) phase = 1;
            1: if (!cal_done) phase = 2;
            default: if (sz0 == 0) phase = 0;
        endcase
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic rand_req(input int pa, input int pw);
        rqA_valid = ($urandom_range(0, 99) < pa); rqA_we = ($urandom_range(0, 99) < pw);
        rqA_addr = AW'($urandom_range(0, 15)); rqA_wdata = rnd(); rqA_bw_n = BWW'($urandom);
        rqB_valid = ($urandom_range(0, 99) < pa); rqB_we = ($urandom_range(0, 99) < pw);
        rqB_addr = AW'($urandom_range(0, 15)); rqB_wdata = rnd(); rqB_bw_n = BWW'($urandom);
    endtask

    initial begin
        rst_clk = 1; cal_done = 0; clear_error = 0;
        rqA_valid = 0; rqA_we = 0; rqA_addr = '0; rqA_wdata = '0; rqA_bw_n = '0;
        rqB_valid = 0; rqB_we = 0; rqB_addr = '0; rqB_wdata = '0; rqB_bw_n = '0;
        user_rd_valid0 = 0; user_rd_data0 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_clk = 0;
        cycle();

        // Basic write then read from A
        cal_done = 1; cycle();
        auto_ret = 1;
        rqA_valid = 1; rqA_we = 1; rqA_addr = 20'h00010;
        rqA_wdata = 72'hAB_CDEF0123_456789AB; rqA_bw_n = 8'h00;
        cycle();
        check_eq("basic_wr_cmd", DW'(user_wr_cmd0), DW'(1));
        check_eq("basic_wr_addr", DW'(user_wr_addr0), DW'(20'h00010));
        rqA_we = 0; cycle();
        check_eq("basic_rd_cmd", DW'(user_rd_cmd0), DW'(1));
        rqA_valid = 0;
        repeat (10) cycle();
        check_eq("basic_rspA_data", rspA_data, 72'hAB_CDEF0123_456789AB);
        check_eq("basic_rspB_data", rspB_data, '0);

        // Contention
        lat_min = 2; lat_max = 6;
        for (int i = 0; i < 8; i++) begin rand_req(100, 50); cycle(); end
        rqA_valid = 0; rqB_valid = 0;
        repeat (12) cycle();

        // Full tag FIFO
        auto_ret = 0; user_rd_valid0 = 0;
        rqA_valid = 1; rqA_we = 0;
        for (int i = 0; i < 8; i++) begin rqA_addr = AW'($urandom); cycle(); end
        check_eq("full_cnt8", DW'(rd_outstanding), DW'(8));
        rqB_valid = 1; rqB_we = 1; rqB_addr = AW'(5); rqB_wdata = rnd(); #1;
        check_eq("full_rdyA", DW'(rqA_ready), '0);
        check_eq("full_rdyB_wr", DW'(rqB_ready), DW'(1));
        cycle();
        rqB_valid = 0; user_rd_valid0 = 1; user_rd_data0 = rnd(); #1;
        check_eq("full_pop_no_relief", DW'(rqA_ready), '0);
        cycle();
        user_rd_valid0 = 0;
        check_eq("full_cnt7", DW'(rd_outstanding), DW'(7));
        check_eq("full_rdyA_again", DW'(rqA_ready), DW'(1));
        cycle();
        rqA_valid = 0;
        for (int i = 0; i < 8; i++) begin user_rd_valid0 = 1; user_rd_data0 = rnd(); cycle(); end
        user_rd_valid0 = 0; cycle();
        check_eq("full_drained", DW'(rd_outstanding), '0);

        // Calibration gating and drain
        auto_ret = 1; cal_done = 0; cycle(); cycle();
        rqA_valid = 1; rqA_we = 0; rqB_valid = 1; rqB_we = 1;
        repeat (3) begin
            cycle();
            check_eq("gate_rdyA", DW'(rqA_ready), '0);
            check_eq("gate_wr_cmd", DW'(user_wr_cmd0), '0);
        end
        rqA_valid = 0; rqB_valid = 0; cal_done = 1; cycle();
        lat_min = 8; lat_max = 10;
        rqA_valid = 1; rqB_valid = 1; rqB_we = 0;
        repeat (3) cycle();
        rqA_valid = 0; rqB_valid = 0; cal_done = 0; cycle();
        check_eq("drain_cnt", DW'(rd_outstanding), DW'(3));
        check_eq("drain_busy", DW'(busy), DW'(1));
        rqA_valid = 1; rqB_valid = 1;
        repeat (3) begin cycle(); check_eq("drain_rdyB", DW'(rqB_ready), '0); end
        rqA_valid = 0; rqB_valid = 0;
        repeat (15) cycle();
        check_eq("drain_idle_busy", DW'(busy), '0);

        // Unexpected return and clearing
        auto_ret = 0; user_rd_valid0 = 1; user_rd_data0 = rnd(); cycle();
        user_rd_valid0 = 0; cycle();
        check_eq("unexp_err", DW'(err_unexpected), DW'(1));
        check_eq("unexp_no_rspA", DW'(rspA_valid), '0);
        clear_error = 1; cycle(); clear_error = 0;
        check_eq("unexp_cleared", DW'(err_unexpected), '0);
        user_rd_valid0 = 1; clear_error = 1; cycle();
        user_rd_valid0 = 0; clear_error = 0;
        check_eq("unexp_set_wins", DW'(err_unexpected), DW'(1));
        clear_error = 1; cycle(); clear_error = 0;

        // Asynchronous reset with reads in flight
        auto_ret = 1; cal_done = 1; cycle();
        lat_min = 12; lat_max = 14;
        rqA_valid = 1; rqA_we = 0; rqB_valid = 1; rqB_we = 0;
        repeat (4) cycle();
        check_eq("arst_cnt4", DW'(rd_outstanding), DW'(4));
        #1 rst_clk = 1;
        #1 check_all_zero("arst");
        model_reset();
        @(posedge clk); #1;
        cyc++;
        rst_clk = 0;
        rqA_valid = 0; rqB_valid = 0;
        repeat (20) cycle();
        check_eq("arst_stale_err", DW'(err_unexpected), DW'(1));
        clear_error = 1; cycle(); clear_error = 0;

        // Randomized traffic
        lat_min = 2; lat_max = 8;
        for (int i = 0; i < 400; i++) begin
            rand_req(70, 40);
            cal_done = ($urandom_range(0, 39) != 0);
            clear_error = ($urandom_range(0, 15) == 0);
            cycle();
        end
        rqA_valid = 0; rqB_valid = 0; clear_error = 0; cal_done = 1;
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/qdrii_port_arbiter.md
Name: qdrii_port_arbiter

Overview:
- Shares user port 0 of one QDRII controller channel (user_*_cmd0/addr0/data0/bw_n0/rd_valid0/rd_data0) between two requesters, A and B.
- Sits in the QDRII user clock domain, between the controller's user interface and host/fabric clients such as the PicoBus bridge and the traffic generator.
- Performs round-robin arbitration, issues at most one command per cycle, and routes returning read data to the requester that issued the read, using an in-order tag FIFO.
- Gates all traffic on cal_done and drains outstanding reads if calibration drops.

Parameters:
ADDR_WIDTH, 20, QDRII word address width
DATA_WIDTH, 72, burst-4 user data width on port 0
BW_WIDTH, 8, byte-write-enable (active-low) width
MAX_OUTSTANDING, 8, read tag FIFO depth (power of 2, >=2)

Ports:
clk  in  1  QDRII user clock (single clock)
rst_clk  in  1  asynchronous, active-high reset
cal_done  in  1  controller calibration complete
clear_error  in  1  synchronous pulse, clears sticky error flags
rqA_valid / rqB_valid  in  1  request present
rqA_ready / rqB_ready  out  1  request accepted this cycle
rqA_we / rqB_we  in  1  1=write, 0=read
rqA_addr / rqB_addr  in  ADDR_WIDTH  word address
rqA_wdata / rqB_wdata  in  DATA_WIDTH  write data
rqA_bw_n / rqB_bw_n  in  BW_WIDTH  byte-write enables, active-low
rspA_valid / rspB_valid  out  1  read data valid, one-cycle pulse
rspA_data / rspB_data  out  DATA_WIDTH  read data
user_wr_cmd0  out  1  write command to controller
user_wr_addr0  out  ADDR_WIDTH  write address
user_wr_data0  out  DATA_WIDTH  write data
user_wr_bw_n0  out  BW_WIDTH  byte-write enables
user_rd_cmd0  out  1  read command to controller
user_rd_addr0  out  ADDR_WIDTH  read address
user_rd_valid0  in  1  read data return strobe
user_rd_data0  in  DATA_WIDTH  read data return
rd_outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy
err_unexpected  out  1  sticky: user_rd_valid0 seen with tag FIFO empty
busy  out  1  state != S_CAL_WAIT or rd_outstanding != 0

Behaviour:
- Clocking and reset: one clock. rst_clk is asynchronous and active-high. While rst_clk is high:
  - all outputs read 0;
  - tag FIFO is empty;
  - round-robin pointer prefers A;
  - state = S_CAL_WAIT.
- FSM:
  - S_CAL_WAIT: no grants. Moves to S_RUN on the first cycle cal_done=1.
  - S_RUN: arbitrates. Moves to S_DRAIN when cal_done=0.
  - S_DRAIN: no grants. Returns to S_CAL_WAIT when rd_outstanding=0.
- Eligibility (S_RUN only):
  - A request is eligible when valid=1, and either we=1, or we=0 and rd_outstanding<MAX_OUTSTANDING.
  - A simultaneous pop does not relieve a full FIFO in the same cycle.
- Arbitration:
  - Round-robin. If both A and B are eligible, the requester not granted last wins; the pointer updates only on a grant. If only one is eligible, it wins.
  - rqX_ready is combinational from the current state, pointer, FIFO count and both valids; at most one ready is high per cycle.
  - Transfer occurs when valid && ready.
- Issue latency:
  - A transfer in cycle N drives user_wr_cmd0 (we=1) or user_rd_cmd0 (we=0) high for exactly cycle N+1, with the matching addr/data/bw_n registered.
  - With no transfer, both cmds are 0 and addr/data/bw_n hold their last value.
- Tag FIFO:
  - A read transfer pushes the requester id (0=A, 1=B) in cycle N.
  - user_rd_valid0 in cycle M pops the head; the popped id selects rspX_valid=1 and rspX_data=user_rd_data0 in cycle M+1.
  - Push and pop in the same cycle leave the count unchanged.
  - Returns are in order and assumed 1:1 with issued reads.
- Unexpected return: user_rd_valid0 with the FIFO empty produces no rsp pulse and sets err_unexpected. The flag is cleared only by clear_error or reset; if set and clear occur together, set wins.
- Reset mid-operation: the FIFO and all in-flight state are discarded. Reads returning after reset are treated as unexpected returns.
- rspX_data holds its value between pulses.

Test Plan:
- Basic write/read: cal_done=1; A writes addr 0x00010, data 72'hAB_CDEF0123_456789AB, bw_n 8'h00, then reads 0x00010. Expect wr_cmd0 one cycle after accept with matching fields, then rd_cmd0. Model returns rd_valid0 + data 5 cycles later; expect rspA_valid with the same data 1 cycle after rd_valid0, and rspB_valid stays 0.
- Contention: A and B valid continuously for 8 cycles, mixing reads and writes. Expect grants alternating A,B,A,B…, exactly one cmd per cycle, and rsp routed per issuing requester.
- Full FIFO: issue 8 reads with no returns. Expect rd_outstanding=8 and read ready=0 while write ready is still granted. One rd_valid0 gives 7, after which a read is accepted the following cycle.
- Calibration gating: hold cal_done=0 with requests pending; expect ready=0 and no cmds. With 3 reads outstanding, drop cal_done: expect S_DRAIN with no grants, busy=1 until the 3 returns arrive and are routed, then busy=0.
- Unexpected return: rd_valid0 with the FIFO empty. Expect no rsp and err_unexpected=1; a clear_error pulse returns it to 0.
- Async reset: assert rst_clk mid-burst with 4 reads outstanding. Expect all outputs 0 immediately and rd_outstanding=0; a stale rd_valid0 after release sets err_unexpected.
